// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// --------------
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Digits are scanned 7,6,...,0. Each slot lasts CLK_DIV cycles. The first DEAD
// cycles of a slot are blanked so that the previous digit's segments cannot
// ghost onto the next anode. Leading zeros can be suppressed, and any digit can
// be masked dark or given a decimal point.
//
// Parameters
//   CLK_DIV    clock cycles per digit slot (DEAD+2 .. 2**20)
//   DEAD       blanking cycles at the start of each slot (>= 1)
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   en         1 = scan, 0 = display dark
//   digit_in   hex nibble selected externally by sel
//   blank_mask bit i forces digit i dark
//   dp_mask    bit i lights the decimal point of digit i
//   lz_blank   1 = suppress leading zeros (digit 0 is never suppressed)
//   sel        current digit index for the external nibble mux
//   an         anode enables, active-low (one-hot-low or all ones)
//   seg        segments a..g on seg[0]..seg[6], active-low
//   dp         decimal point, active-low
//   frame_done one-cycle pulse after the last slot of a frame
`timescale 1ns/1ps
module seg7_scan_ctrl #(
    parameter int CLK_DIV = 1000,
    parameter int DEAD    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] digit_in,
    input  logic [7:0] blank_mask,
    input  logic [7:0] dp_mask,
    input  logic       lz_blank,
    output logic [2:0] sel,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_M1  = CW'(DEAD - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          nz;          // a non-zero, unmasked digit has been shown this frame

    logic [6:0]    seg_dec;
    logic          masked;
    logic          suppressed;
    logic          lit;
    logic [7:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    // Hex to active-low segments, bit order g f e d c b a.
    always_comb begin
        seg_dec = 7'h7F;
        unique case (digit_in)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
        endcase
    end

    // NOTE: every signal gets a default before any conditional update, so no
    // path through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        masked     = blank_mask[sel];
        suppressed = lz_blank && !nz && (digit_in == 4'h0) && (sel != 3'd0);
        lit        = (state == SHOW) && !masked && !suppressed;
        an_nxt     = 8'hFF;
        seg_nxt    = 7'h7F;
        dp_nxt     = 1'b1;
        if (lit) begin
            an_nxt  = ~(8'd1 << sel);
            seg_nxt = seg_dec;
            dp_nxt  = ~dp_mask[sel];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 3'd7;
            nz         <= 1'b0;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            // Outputs are registered from this cycle's state, sel and digit_in.
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= 1'b0;

            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                sel   <= 3'd7;
                an    <= 8'hFF;
                seg   <= 7'h7F;
                dp    <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= BLANK;
                        cnt   <= '0;
                        sel   <= 3'd7;
                        nz    <= 1'b0;
                    end
                    default: begin
                        if (state == SHOW && digit_in != 4'h0 && !masked)
                            nz <= 1'b1;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            sel   <= sel - 3'd1;   // 0 wraps to 7
                            state <= BLANK;
                            if (sel == 3'd0) begin
                                // Next slot is digit 7: a new frame begins.
                                nz         <= 1'b0;
                                frame_done <= 1'b1;
                            end
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= (cnt >= DEAD_M1) ? SHOW : BLANK;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000: clock cycles per digit slot; legal range DEAD+2..2^20.
REQ-002 SHALL have parameter DEAD, default 4: blanking cycles at the start of each slot (anti-ghosting); legal range >= 1.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: 1 = scan display, 0 = display dark.
REQ-006 SHALL have port digit_in, input, 4 bits: hex nibble from the external 8:1 nibble mux, combinationally selected by sel.
REQ-007 SHALL have port blank_mask, input, 8 bits: bit i = 1 forces digit i dark.
REQ-008 SHALL have port dp_mask, input, 8 bits: bit i = 1 lights the decimal point on digit i.
REQ-009 SHALL have port lz_blank, input, 1 bit: 1 = suppress leading zeros.
REQ-010 SHALL have port sel, output, 3 bits: digit index driven to the mux select.
REQ-011 SHALL have port an, output, 8 bits: anode enables, active-low, one-hot-low or all ones.
REQ-012 SHALL have port seg, output, 7 bits: segments, active-low, seg[0]=a ... seg[6]=g.
REQ-013 SHALL have port dp, output, 1 bit: decimal point, active-low.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full 8-digit frame.

Function
REQ-015 SHALL implement the states IDLE, BLANK and SHOW.
REQ-016 SHALL hold a prescaler cnt counting 0..CLK_DIV-1 while in BLANK or SHOW; a slot ends when cnt = CLK_DIV-1.
REQ-017 SHALL scan digits in the order 7,6,...,0, then wrap to 7; sel decrements at each slot end, 0 -> 7.
REQ-018 SHALL use BLANK for cnt 0..DEAD-1 and SHOW for cnt DEAD..CLK_DIV-1 within each slot.
REQ-019 SHALL go from IDLE to BLANK when en=1, with sel=7 and cnt=0.
REQ-020 SHALL go from any state to IDLE when en=0 on the next edge: cnt=0, sel=7, and outputs dark from the following cycle.
REQ-021 SHALL register an, seg and dp, so the outputs reflect the state, sel and digit_in of the previous cycle (1-cycle latency).
REQ-022 SHALL drive an[sel]=0 only while in SHOW with the digit not dark; all other an bits SHALL be 1.
REQ-023 SHALL drive an=8'hFF, seg=7'h7F and dp=1 in IDLE and BLANK.
REQ-024 SHALL treat a digit as dark when blank_mask[sel]=1 or the digit is leading-zero suppressed; a dark digit SHALL output an=8'hFF, seg=7'h7F and dp=1.
REQ-025 SHALL implement leading-zero suppression with a flag nz that is cleared on entry to slot 7, and set in SHOW when digit_in != 0 and blank_mask[sel] = 0.
REQ-026 SHALL treat a digit as suppressed iff lz_blank=1, nz=0, digit_in=0 and sel != 0; digit 0 SHALL never be suppressed.
REQ-027 SHALL NOT let a blank_mask'd digit set nz.
REQ-028 SHALL decode digit_in as hex 0-F with active-low segments; examples: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, A = 7'b0001000, F = 7'b0001110.
REQ-029 SHALL drive dp = ~dp_mask[sel] for a lit digit.
REQ-030 SHALL pulse frame_done for 1 cycle on the cycle after the slot end with sel=0.
REQ-031 SHALL sample mask and lz_blank changes every cycle, taking effect with 1-cycle latency; there SHALL be no mid-slot hold.

Reset
REQ-032 SHALL, while rst_n=0 at a clock edge, set state=IDLE, cnt=0, sel=7, nz=0, an=8'hFF, seg=7'h7F, dp=1 and frame_done=0.
REQ-033 SHALL let reset override en and abort any slot in progress.
REQ-034 SHALL, after release with en=1, enter BLANK on the first edge.

Verification (bench: CLK_DIV=16, DEAD=2)
REQ-035 SHALL cover: reset, then en=1 with digits 7..0 = 1,2,3,4,5,6,7,8 -> an walks 7F,BF,...,FE; each digit is lit 14 cycles per 16-cycle slot; seg for digit 0 = 7'b0000000; frame_done pulses once every 128 cycles.
REQ-036 SHALL cover: lz_blank=1 with digits 0,0,0,4,0,0,0,0 -> digits 7..5 dark; digits 4..0 lit, showing 4,0,0,0,0.
REQ-037 SHALL cover: all digits 0 with lz_blank=1 -> only digit 0 lit, showing 7'b1000000.
REQ-038 SHALL cover: blank_mask=8'h81 and dp_mask=8'h04 -> digits 7 and 0 never lit; dp=0 only while an=8'hFB.
REQ-039 SHALL cover: en dropped mid-SHOW of digit 3 -> an=8'hFF within 2 cycles and sel=7; re-raising en restarts from digit 7 at cnt 0.
REQ-040 SHALL cover: rst_n=0 asserted mid-frame for 1 cycle -> next cycle an=8'hFF, sel=7, frame_done=0; scanning restarts from digit 7.
